// File: rtl/exec_time_uart_report.sv
// Captures a DATA_WIDTH-bit value on a trigger rising edge and reports it over UART 8N1
// as uppercase hex digits (MS nibble first) followed by CR LF.
module exec_time_uart_report #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trigger,
    input  logic [DATA_WIDTH-1:0] value,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);
    localparam int DIV     = CLK_HZ / BAUD;
    localparam int NIBBLES = DATA_WIDTH / 4;
    localparam int NCHARS  = NIBBLES + 2;
    localparam int BW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW      = $clog2(NCHARS);

    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(DIV - 2);
    localparam logic [CW-1:0] IDX_CR    = CW'(NIBBLES);
    localparam logic [CW-1:0] IDX_LF    = CW'(NCHARS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state;
    logic                  trig_q;
    logic [BW-1:0]         baud_cnt;
    logic [2:0]            bit_cnt;
    logic [CW-1:0]         char_idx;
    logic [DATA_WIDTH-1:0] shadow;

    logic       trig_edge;
    logic       baud_end;
    logic       last_char;
    logic [2:0] next_bit;
    logic [3:0] nib;
    logic [7:0] cur_char;

    assign trig_edge = trigger & ~trig_q;
    assign baud_end  = (baud_cnt == BAUD_LAST);
    assign last_char = (char_idx == IDX_LF);
    assign next_bit  = bit_cnt + 3'd1;

    // Character for the current index: hex digit of the selected nibble, then CR, then LF.
    always_comb begin
        nib = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (char_idx == CW'(n))
                nib = shadow[DATA_WIDTH-1-4*n -: 4];
        end
        if (char_idx == IDX_CR)
            cur_char = 8'h0D;
        else if (char_idx == IDX_LF)
            cur_char = 8'h0A;
        else if (nib < 4'd10)
            cur_char = {4'h3, nib};
        else
            cur_char = 8'h37 + {4'h0, nib};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            trig_q   <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            char_idx <= '0;
            shadow   <= '0;
        end else begin
            trig_q <= trigger;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig_edge) begin
                        shadow   <= value;
                        char_idx <= '0;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= cur_char[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= next_bit;
                            tx      <= cur_char[next_bit];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (last_char) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            char_idx <= char_idx + 1'b1;
                            tx       <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                        // done is registered, so raise it one cycle early to land on the final stop cycle
                        if (last_char && baud_cnt == BAUD_PRE)
                            done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
